// File: rtl/load_arbiter_pkg.sv
// Shared types and constants for the three-requester load arbiter.
// Holds the FSM state encoding and the round-robin pointer helper.
package load_arbiter_pkg;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    // Pointer value that puts the requester after the winner first.
    function automatic logic [1:0] next_ptr(input logic [NUM_REQ-1:0] win);
        logic [1:0] p;
        p = 2'd0;
        if (win[0]) p = 2'd1;
        else if (win[1]) p = 2'd2;
        return p;
    endfunction

endpackage

// File: rtl/load_arb_pick.sv
// Combinational winner selection for the load arbiter.
// Priority starts at ptr and wraps; ptr 3 is treated as 0.
module load_arb_pick
    import load_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Rotated priority encoder producing a one-hot winner.
    always_comb begin
        grant = '0;
        case (ptr)
            2'd1: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            2'd2: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/load_arbiter.sv
// Three-way arbiter loading a shared 8-bit register: IDLE -> GRANT -> ACK.
// Define LOAD_ARBITER_RR_EN for round-robin; default is fixed 0 > 1 > 2.
module load_arbiter
    import load_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic              ack0,
    output logic              ack1,
    output logic              ack2,
    output logic              load0,
    output logic              load1,
    output logic              load2,
    output logic [DATA_W-1:0] data_in0,
    output logic [DATA_W-1:0] data_in1,
    output logic [DATA_W-1:0] data_in2,
    output logic              busy
);

    state_t             state;
    logic [NUM_REQ-1:0] req_v;
    logic [NUM_REQ-1:0] win;
    logic [NUM_REQ-1:0] win_q;
    logic [NUM_REQ-1:0] load_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [1:0]         ptr;

    assign req_v = {req2, req1, req0};

    load_arb_pick u_pick (
        .req   (req_v),
        .ptr   (ptr),
        .grant (win)
    );

    // Main FSM: captures the winner and its payload, then issues load and ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            win_q    <= '0;
            load_q   <= '0;
            ack_q    <= '0;
            data_in0 <= '0;
            data_in1 <= '0;
            data_in2 <= '0;
        end else begin
            load_q <= '0;
            ack_q  <= '0;
            case (state)
                IDLE: begin
                    if (|req_v) begin
                        win_q  <= win;
                        load_q <= win;
                        state  <= GRANT;
                        if (win[0]) data_in0 <= data0;
                        if (win[1]) data_in1 <= data1;
                        if (win[2]) data_in2 <= data2;
                    end
                end
                GRANT: begin
                    ack_q <= win_q;
                    state <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LOAD_ARBITER_RR_EN
    // Round-robin pointer moves past the winner during its ack cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 2'd0;
        end else if (state == ACK) begin
            ptr <= next_ptr(win_q);
        end
    end
`else
    assign ptr = 2'd0;
`endif

    assign load0 = load_q[0];
    assign load1 = load_q[1];
    assign load2 = load_q[2];
    assign ack0  = ack_q[0];
    assign ack1  = ack_q[1];
    assign ack2  = ack_q[2];
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_load_arbiter.sv
// Directed self-checking bench for load_arbiter.
// Expectations follow LOAD_ARBITER_RR_EN when it is defined.
module tb_load_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, req2;
    logic [7:0] data0, data1, data2;
    logic       ack0, ack1, ack2;
    logic       load0, load1, load2;
    logic [7:0] data_in0, data_in1, data_in2;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    wire [2:0] ld = {load2, load1, load0};
    wire [2:0] ak = {ack2, ack1, ack0};

    always #5 clk = ~clk;

    load_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .req2     (req2),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .ack0     (ack0),
        .ack1     (ack1),
        .ack2     (ack2),
        .load0    (load0),
        .load1    (load1),
        .load2    (load2),
        .data_in0 (data_in0),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({ld, ak, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outs got %b want 0", {ld, ak, busy});
        end
        n_cmp++;
        if ({data_in2, data_in1, data_in0} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_data got %h want 000000",
                     {data_in2, data_in1, data_in0});
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({ld, ak, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL idle_quiet got %b want 0", {ld, ak, busy});
        end
    endtask

    task automatic test_single();
        req1 = 1'b1;
        data1 = 8'hA5;
        step();
        req1 = 1'b0;
        n_cmp++;
        if ({ld, ak, busy, data_in1} !== {3'b010, 3'b000, 1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL single_grant got %b %b %b %h want 010 000 1 a5",
                     ld, ak, busy, data_in1);
        end
        step();
        n_cmp++;
        if ({ld, ak, busy} !== {3'b000, 3'b010, 1'b1}) begin
            n_err++;
            $display("FAIL single_ack got %b %b %b want 000 010 1",
                     ld, ak, busy);
        end
        step();
        n_cmp++;
        if ({ld, ak, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL single_idle got %b %b %b want 0", ld, ak, busy);
        end
    endtask

    task automatic test_all_req();
        logic [2:0] seq [3];
        logic [2:0] exp [3];
        int n_ack;
        int bad;
`ifdef LOAD_ARBITER_RR_EN
        exp[0] = 3'b001; exp[1] = 3'b010; exp[2] = 3'b100;
`else
        exp[0] = 3'b001; exp[1] = 3'b001; exp[2] = 3'b001;
`endif
        do_reset();
        n_ack = 0;
        bad = 0;
        {req2, req1, req0} = 3'b111;
        data0 = 8'h11; data1 = 8'h22; data2 = 8'h33;
        for (int i = 0; i < 9; i++) begin
            step();
            if ($countones(ld) > 1 || $countones(ak) > 1) bad++;
            if (ld != 3'b000 && ak != 3'b000) bad++;
            if (ak != 3'b000) begin
                if (n_ack < 3) seq[n_ack] = ak;
                n_ack++;
            end
        end
        {req2, req1, req0} = 3'b000;
        n_cmp++;
        if (n_ack !== 3) begin
            n_err++;
            $display("FAIL all_ack_count got %0d want 3", n_ack);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL all_onehot got %0d want 0 violations", bad);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (n_ack < i + 1 || seq[i] !== exp[i]) begin
                n_err++;
                $display("FAIL all_order%0d got %b want %b", i, seq[i], exp[i]);
            end
        end
        step();
        step();
        step();
    endtask

    task automatic test_pulse();
        req2 = 1'b1;
        data2 = 8'h5C;
        step();
        req2 = 1'b0;
        data2 = 8'hFF;
        n_cmp++;
        if ({ld, data_in2} !== {3'b100, 8'h5C}) begin
            n_err++;
            $display("FAIL pulse_load got %b %h want 100 5c", ld, data_in2);
        end
        step();
        n_cmp++;
        if (ak !== 3'b100) begin
            n_err++;
            $display("FAIL pulse_ack got %b want 100", ak);
        end
        step();
        step();
        n_cmp++;
        if ({ld, ak, busy, data_in2} !== {7'b0, 8'h5C}) begin
            n_err++;
            $display("FAIL pulse_hold got %b %b %b %h want 0 0 0 5c",
                     ld, ak, busy, data_in2);
        end
    endtask

    task automatic test_busy_ignore();
        do_reset();
        req1 = 1'b1;
        data1 = 8'h77;
        step();
        req1 = 1'b0;
        req0 = 1'b1;
        data0 = 8'h99;
        step();
        n_cmp++;
        if ({ld, ak} !== {3'b000, 3'b010}) begin
            n_err++;
            $display("FAIL busy_ack1 got %b %b want 000 010", ld, ak);
        end
        step();
        n_cmp++;
        if ({ld, ak, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL busy_ignored got %b %b %b want 0", ld, ak, busy);
        end
        step();
        req0 = 1'b0;
        n_cmp++;
        if ({ld, data_in0, data_in1} !== {3'b001, 8'h99, 8'h77}) begin
            n_err++;
            $display("FAIL busy_load0 got %b %h %h want 001 99 77",
                     ld, data_in0, data_in1);
        end
        step();
        n_cmp++;
        if (ak !== 3'b001) begin
            n_err++;
            $display("FAIL busy_ack0 got %b want 001", ak);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int seen;
        req0 = 1'b1;
        data0 = 8'h3C;
        step();
        req0 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({ld, ak, busy, data_in0, data_in1, data_in2} !== {7'b0, 24'h0}) begin
            n_err++;
            $display("FAIL abort_state got %b %b %b %h %h %h want 0",
                     ld, ak, busy, data_in0, data_in1, data_in2);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ld != 3'b000 || ak != 3'b000 || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_quiet got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req2 = 1'b1;
        data2 = 8'hA1;
        step();
        req0 = 1'b1;
        data0 = 8'hB2;
        n_cmp++;
        if (ld !== 3'b100) begin
            n_err++;
            $display("FAIL wrap_first got %b want 100", ld);
        end
        step();
        step();
        step();
        req0 = 1'b0;
        n_cmp++;
        if ({ld, data_in0} !== {3'b001, 8'hB2}) begin
            n_err++;
            $display("FAIL wrap_second got %b %h want 001 b2", ld, data_in0);
        end
        step();
        step();
        step();
        req2 = 1'b0;
        n_cmp++;
        if (ld !== 3'b100) begin
            n_err++;
            $display("FAIL wrap_third got %b want 100", ld);
        end
        step();
        step();
        step();
    endtask

    initial begin
        reset = 1'b0;
        {req2, req1, req0} = 3'b000;
        data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
        test_reset();
        test_single();
        test_all_req();
        test_pulse();
        test_busy_ignore();
        test_reset_abort();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_arbiter.md
LOAD_ARBITER -- requirements
Module: load_arbiter

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have the ports req0/req1/req2, input, 1 bit each: requester asks to load the shared 8-bit register.
REQ-004 The module SHALL have the ports data0/data1/data2, input, 8 bits each: requester payload, held stable while its req is high.
REQ-005 The module SHALL have the ports ack0/ack1/ack2, output, 1 bit each: one-cycle completion pulse to the granted requester.
REQ-006 The module SHALL have the ports load0/load1/load2, output, 1 bit each: one-hot load strobes to the shared register.
REQ-007 The module SHALL have the ports data_in0/data_in1/data_in2, output, 8 bits each: latched payloads driven to the shared register.
REQ-008 The module SHALL have the port busy, output, 1 bit: high while a transfer is in flight (GRANT or ACK state).

Function
REQ-009 The FSM SHALL have exactly the states IDLE, GRANT and ACK.
REQ-010 In IDLE, with any reqN sampled high at edge N, the FSM SHALL select one winner, latch its data into data_inW and enter GRANT at edge N.
REQ-011 In GRANT, exactly one of load0/load1/load2 SHALL be high for exactly one cycle, and the FSM SHALL enter ACK.
REQ-012 In ACK, ackW SHALL be high for exactly one cycle and the FSM SHALL return to IDLE; latency from req sampled to ack high is 2 cycles.
REQ-013 In IDLE with no req high, all load and ack outputs SHALL stay 0 and the FSM SHALL remain in IDLE.
REQ-014 At most one load strobe and at most one ack SHALL be high in any cycle, and never in the same cycle.
REQ-015 Once issued, a grant SHALL be committed: deasserting the winner's req in GRANT still produces load then ack.
REQ-016 Requests arriving while busy SHALL be ignored until the return to IDLE; they are not queued beyond the level of req.
REQ-017 A requester holding req high after its ack SHALL be treated as a new request at the next IDLE evaluation (back-to-back = 3-cycle period).
REQ-018 data_inN SHALL change only on a grant to requester N and SHALL otherwise hold its last value.
REQ-019 busy SHALL equal (state != IDLE).

Reset
REQ-020 While reset is high at a clk edge, the FSM SHALL go to IDLE and load*, ack* and busy SHALL be 0 in the following cycle.
REQ-021 Reset SHALL set data_in0/1/2 to 8'h00 and the round-robin pointer (if present) to requester 0.
REQ-022 Reset asserted in GRANT or ACK SHALL abort the transfer; no load or ack pulse SHALL follow reset release without a new request.

Configuration
REQ-023 LOAD_ARBITER_RR_EN undefined: arbitration SHALL be fixed priority 0 > 1 > 2.
REQ-024 LOAD_ARBITER_RR_EN defined: arbitration SHALL be round-robin via a 2-bit pointer, initial priority order 0,1,2.
REQ-025 With LOAD_ARBITER_RR_EN defined, on each ack the pointer SHALL advance to winner+1, wrapping 2 -> 0, and priority order SHALL start at the pointer.
REQ-026 With LOAD_ARBITER_RR_EN defined, the pointer SHALL never hold value 3.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, GRANT, ACK), the requester count constant (3) and the data width constant (8).
REQ-028 Winner selection SHALL be one sub-module, load_arb_pick: combinational, inputs req[2:0] plus the pointer, output a one-hot winner.

Verification
REQ-029 req1=1, data1=8'hA5 from IDLE -> load1 pulses at cycle +1 with data_in1=8'hA5, ack1 pulses at cycle +2, busy high for cycles +1 and +2.
REQ-030 req0=req1=req2=1 held for 9 cycles, fixed priority -> three grants all to requester 0; with RR_EN -> grant order 0,1,2.
REQ-031 req2 pulsed for 1 cycle only -> load2 and ack2 still each pulse once; data_in2 holds the captured value.
REQ-032 req0 raised in the GRANT cycle of requester 1's transfer -> no effect until IDLE; requester 0 is served next, with ack0 3 cycles after ack1.
REQ-033 reset asserted in the GRANT cycle -> no load or ack pulse afterwards, busy=0, data_in*=8'h00, FSM in IDLE.
REQ-034 RR_EN: req2 only, then req0 and req2 together -> req2 first, then req0 (pointer wrapped 2 -> 0).
